stage_sequencer: RTL

//  Top-level game-flow controller: sequences iris-in, play, iris-out and dark hold between stages.

---
 rtl/game_pkg.sv | 19 +
 rtl/stage_sequencer_if.sv | 26 ++
 rtl/stage_sequencer_rst_pulse_gen.sv | 34 +++
 rtl/stage_sequencer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the stage sequencer: state encoding, radius width and
// the pending-outcome type remembered while the iris closes.
package game_pkg;

  localparam int RADIUS_W        = 10;
  localparam int MAX_RADIUS_DFLT = 640;

  localparam logic [2:0] S_OPEN      = 3'd0;
  localparam logic [2:0] S_PLAY      = 3'd1;
  localparam logic [2:0] S_CLOSE     = 3'd2;
  localparam logic [2:0] S_HOLD      = 3'd3;
  localparam logic [2:0] S_GAME_OVER = 3'd4;

  typedef enum logic {
    PEND_DIE = 1'b0,
    PEND_WIN = 1'b1
  } pending_e;

endpackage

// File: rtl/stage_sequencer_if.sv
// Signal bundle between the sequencer, the game logic and the VGA mask unit.
// master = the sequencer itself; slave = the game/mask side.
interface stage_sequencer_if;
  import game_pkg::*;

  logic                frame_tick;
  logic [1:0]          over;
  logic                start;
  logic [RADIUS_W-1:0] radius;
  logic                mask_bypass;
  logic                game_rstn;
  logic [1:0]          stage;
  logic [1:0]          lives;
  logic                game_over;

  modport master (
    input  frame_tick, over, start,
    output radius, mask_bypass, game_rstn, stage, lives, game_over
  );

  modport slave (
    output frame_tick, over, start,
    input  radius, mask_bypass, game_rstn, stage, lives, game_over
  );

endinterface

// File: rtl/stage_sequencer_rst_pulse_gen.sv
// Holds the game-world reset low for RST_CYCLES clocks after system reset
// release or after a trigger pulse.
module rst_pulse_gen #(
  parameter int RST_CYCLES = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic trigger,
  output logic game_rstn
);

  localparam int CNT_W = $clog2(RST_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments only, and reset is
  // sampled on the clock edge (synchronous) rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt       <= CNT_W'(RST_CYCLES);
      game_rstn <= 1'b0;
    end else if (trigger) begin
      // The trigger edge itself already drives game_rstn low, so one less to go.
      cnt       <= CNT_W'(RST_CYCLES - 1);
      game_rstn <= 1'b0;
    end else if (cnt != '0) begin
      cnt       <= cnt - 1'b1;
      game_rstn <= 1'b0;
    end else begin
      game_rstn <= 1'b1;
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Game-flow controller: iris-in, play, iris-out and dark hold between stages,
// with stage/lives bookkeeping and a game-over state awaiting restart.
module stage_sequencer
  import game_pkg::*;
#(
  parameter int MAX_RADIUS  = MAX_RADIUS_DFLT,
  parameter int STEP        = 4,
  parameter int HOLD_FRAMES = 30,
  parameter int RST_CYCLES  = 8,
  parameter int INIT_LIVES  = 3,
  parameter int NUM_STAGES  = 4
) (
  input logic                clk,
  input logic                rstn,
  stage_sequencer_if.master  bus
);

  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [RADIUS_W:0]   STEP_X    = (RADIUS_W + 1)'(STEP);
  localparam logic [RADIUS_W:0]   MAX_X     = (RADIUS_W + 1)'(MAX_RADIUS);
  localparam logic [RADIUS_W-1:0] STEP_R    = RADIUS_W'(STEP);
  localparam logic [RADIUS_W-1:0] MAX_R     = RADIUS_W'(MAX_RADIUS);
  localparam logic [1:0]          LIVES_0   = 2'(INIT_LIVES);
  localparam logic [1:0]          LAST_STG  = 2'(NUM_STAGES - 1);

  logic [2:0]          state;
  logic [RADIUS_W-1:0] radius;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [1:0]          stage;
  logic [1:0]          lives;
  pending_e            pending;
  logic                mask_bypass;
  logic                game_over;

  logic [RADIUS_W:0]   radius_up;
  logic                open_done;
  logic                close_done;
  logic                world_reset;
  logic [1:0]          next_stage;

  // Radius math is one bit wider so the opening sum cannot wrap before saturating.
  assign radius_up   = {1'b0, radius} + STEP_X;
  assign open_done   = radius_up >= MAX_X;
  assign close_done  = {1'b0, radius} <= STEP_X;
  assign world_reset = (state == S_HOLD) && bus.frame_tick && (hold_cnt == HOLD_LAST);
  assign next_stage  = (stage == LAST_STG) ? 2'd0 : stage + 2'd1;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= S_OPEN;
      radius      <= '0;
      hold_cnt    <= '0;
      stage       <= 2'd0;
      lives       <= LIVES_0;
      pending     <= PEND_WIN;
      mask_bypass <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      case (state)
        S_OPEN: if (bus.frame_tick) begin
          if (open_done) begin
            radius      <= MAX_R;
            state       <= S_PLAY;
            mask_bypass <= 1'b1;
          end else begin
            radius <= radius_up[RADIUS_W-1:0];
          end
        end
        S_PLAY: begin
          radius <= MAX_R;
          // Death has priority when both flags are raised together.
          if (bus.over[1]) begin
            lives       <= (lives == 2'd0) ? 2'd0 : lives - 2'd1;
            pending     <= PEND_DIE;
            state       <= S_CLOSE;
            mask_bypass <= 1'b0;
          end else if (bus.over[0]) begin
            pending     <= PEND_WIN;
            state       <= S_CLOSE;
            mask_bypass <= 1'b0;
          end
        end
        S_CLOSE: if (bus.frame_tick) begin
          if (close_done) begin
            radius   <= '0;
            hold_cnt <= '0;
            if (pending == PEND_WIN) stage <= next_stage;
            if (lives != 2'd0) begin
              state <= S_HOLD;
            end else begin
              state     <= S_GAME_OVER;
              game_over <= 1'b1;
            end
          end else begin
            radius <= radius - STEP_R;
          end
        end
        S_HOLD: begin
          radius <= '0;
          if (bus.frame_tick) begin
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt <= '0;
              state    <= S_OPEN;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        S_GAME_OVER: begin
          radius <= '0;
          if (bus.start) begin
            lives     <= LIVES_0;
            stage     <= 2'd0;
            game_over <= 1'b0;
            hold_cnt  <= '0;
            state     <= S_HOLD;
          end
        end
        default: state <= S_OPEN;
      endcase
    end
  end

  rst_pulse_gen #(.RST_CYCLES(RST_CYCLES)) u_rst_pulse_gen (
    .clk       (clk),
    .rstn      (rstn),
    .trigger   (world_reset),
    .game_rstn (bus.game_rstn)
  );

  assign bus.radius      = radius;
  assign bus.mask_bypass = mask_bypass;
  assign bus.stage       = stage;
  assign bus.lives       = lives;
  assign bus.game_over   = game_over;

endmodule
